led_blink_drv: RTL and testbench
================================

// Module: led_blink_drv
// PURPOSE
//  Output-side counterpart of the debounced key capture: turns one-cycle event pulses into
//  human-visible LED blink bursts on a board pin. Sits between event sources (key capture
//  strobe, link/status events) and an LED pad. Events arriving during a burst are queued
//  in a saturating counter and played back-to-back.
// PARAMETERS
//  CLK_FREQ  100000000  input clock frequency, Hz
//  ON_MS     100        LED on time per blink, ms (>=1)
//  OFF_MS    100        LED off time per blink, ms (>=1)
//  BLINKS    3          blinks per burst (>=1)
//  PEND_W    4          width of pending-burst counter
// PORTS
//  clk_i   in   1       clock
//  rst_i   in   1       synchronous reset, active-high
//  trig_i  in   1       event strobe, one cycle wide, sampled every clock
//  led_o   out  1       LED drive, registered
//  busy_o  out  1       high while a burst is playing
//  pend_o  out  PEND_W  queued bursts not yet started
// BEHAVIOUR
//  - Derived: ON_CYC=CLK_FREQ/1000*ON_MS, OFF_CYC=CLK_FREQ/1000*OFF_MS; 32-bit phase counter.
//  - Reset: state IDLE, led_o=0, busy_o=0, pend_o=0, phase and blink counters 0. Takes effect
//    on the next edge from any state; trig_i is ignored while rst_i=1.
//  - FSM IDLE/ON/OFF. ON: led_o=1 for exactly ON_CYC cycles. OFF: led_o=0 for OFF_CYC cycles.
//  - IDLE & trig_i (pend_o==0 there by construction): next cycle ON, blink=1, busy_o=1.
//    Latency trig_i->led_o rising edge = 1 clock.
//  - ON end -> OFF. OFF end with blink<BLINKS -> ON, blink+1.
//  - OFF end with blink==BLINKS (burst end):
//      pend_o>0 -> ON next cycle, blink=1, pend_o-1 (no idle gap, busy_o stays 1);
//      pend_o==0 & trig_i same cycle -> ON next cycle, pend_o stays 0;
//      pend_o==0 & no trig -> IDLE, busy_o=0 next cycle.
//  - trig_i while busy (except burst-end case above): pend_o+1, saturating at 2**PEND_W-1;
//    further events dropped. trig_i + decrement in same cycle: pend_o unchanged.
//  - Burst length = BLINKS*(ON_CYC+OFF_CYC) cycles; busy_o covers exactly that span.
//  - led_o, busy_o, pend_o all registered; no combinational path from trig_i.
// CONFIGURATION
//  LED_ACTIVE_LOW_EN: defined -> led_o inverted (reset value 1, 0 during ON) for
//  active-low LED pads. Undefined -> active-high as above. Other outputs unaffected.
// TESTING  (CLK_FREQ=1000, ON_MS=3, OFF_MS=2, BLINKS=2, PEND_W=2 unless noted)
//  1 reset, single trig_i at cycle 10 -> led_o high 11-13, low 14-15, high 16-18, low 19-20;
//    busy_o high 11-20, low at 21; pend_o=0 throughout.
//  2 trig at 10 and 12 -> pend_o=1 at 13; second burst starts at 21 (no gap), pend_o=0 at 21,
//    busy_o falls at 31.
//  3 five trigs during one burst -> pend_o saturates at 3; exactly 4 bursts total, then idle.
//  4 trig exactly on cycle 20 (last OFF cycle, pend 0) -> led_o high at 21, pend_o stays 0.
//  5 rst_i pulsed at cycle 15 mid-burst with pend_o=2 -> at 16 led_o=0, busy_o=0, pend_o=0;
//    trig while rst_i=1 produces no burst.
//  6 LED_ACTIVE_LOW_EN defined, repeat test 1 -> led_o=1 after reset, 0 on cycles 11-13, 16-18.

Source files
------------

// File: rtl/led_blink_drv.sv
// led_blink_drv: turns one-cycle event strobes into LED blink bursts, queuing extra events.
// Build option: define LED_ACTIVE_LOW_EN to drive an active-low LED pad.
module led_blink_drv #(
    parameter int CLK_FREQ = 100000000,
    parameter int ON_MS    = 100,
    parameter int OFF_MS   = 100,
    parameter int BLINKS   = 3,
    parameter int PEND_W   = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    output logic              led_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pend_o
);

    // state | meaning
    // IDLE  | no burst playing, LED dark
    // ON    | LED lit, phase counts down ON_CYC cycles
    // OFF   | LED dark, phase counts down OFF_CYC cycles

    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;

    localparam logic [31:0] ON_LOAD  = 32'(CLK_FREQ / 1000 * ON_MS - 1);
    localparam logic [31:0] OFF_LOAD = 32'(CLK_FREQ / 1000 * OFF_MS - 1);
    localparam int BLINK_W = $clog2(BLINKS + 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINKS);
    localparam logic [PEND_W-1:0]  PEND_MAX   = '1;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_LIT = 1'b0;
`else
    localparam logic LED_LIT = 1'b1;
`endif
    localparam logic LED_DARK = ~LED_LIT;

    state_t             state;
    logic [31:0]        phase;
    logic [BLINK_W-1:0] blink;
    logic [PEND_W-1:0]  pend_inc;

    // Saturating increment: events beyond the queue depth are dropped.
    assign pend_inc = (pend_o == PEND_MAX) ? pend_o : pend_o + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            phase  <= '0;
            blink  <= '0;
            led_o  <= LED_DARK;
            busy_o <= 1'b0;
            pend_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig_i) begin
                        state  <= ST_ON;
                        phase  <= ON_LOAD;
                        blink  <= BLINK_ONE;
                        led_o  <= LED_LIT;
                        busy_o <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (trig_i)
                        pend_o <= pend_inc;
                    if (phase == 32'd0) begin
                        state <= ST_OFF;
                        phase <= OFF_LOAD;
                        led_o <= LED_DARK;
                    end else begin
                        phase <= phase - 32'd1;
                    end
                end
                ST_OFF: begin
                    if (phase != 32'd0) begin
                        phase <= phase - 32'd1;
                        if (trig_i)
                            pend_o <= pend_inc;
                    end else if (blink != BLINK_LAST) begin
                        state <= ST_ON;
                        phase <= ON_LOAD;
                        blink <= blink + 1'b1;
                        led_o <= LED_LIT;
                        if (trig_i)
                            pend_o <= pend_inc;
                    end else if (pend_o != '0) begin
                        // Queued burst starts back-to-back; a coincident trig replaces the one consumed.
                        state <= ST_ON;
                        phase <= ON_LOAD;
                        blink <= BLINK_ONE;
                        led_o <= LED_LIT;
                        if (!trig_i)
                            pend_o <= pend_o - 1'b1;
                    end else if (trig_i) begin
                        state <= ST_ON;
                        phase <= ON_LOAD;
                        blink <= BLINK_ONE;
                        led_o <= LED_LIT;
                    end else begin
                        state  <= ST_IDLE;
                        blink  <= '0;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    phase  <= '0;
                    blink  <= '0;
                    led_o  <= LED_DARK;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_drv.sv
// tb_led_blink_drv: directed scoreboard bench for led_blink_drv (small timing parameters).
// Expectations are queued per cycle from the burst timeline and checked as cycles elapse.
module tb_led_blink_drv;

    localparam int CLK_FREQ = 1000;
    localparam int ON_MS    = 3;
    localparam int OFF_MS   = 2;
    localparam int BLINKS   = 2;
    localparam int PEND_W   = 2;
    localparam int ON_C     = CLK_FREQ / 1000 * ON_MS;
    localparam int OFF_C    = CLK_FREQ / 1000 * OFF_MS;
    localparam int PERIOD   = ON_C + OFF_C;
    localparam int BURST    = BLINKS * PERIOD;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic [3:0] LED_INV = 4'd1;
`else
    localparam logic [3:0] LED_INV = 4'd0;
`endif

    localparam int SIG_LED  = 0;
    localparam int SIG_BUSY = 1;
    localparam int SIG_PEND = 2;

    logic              clk_i  = 1'b0;
    logic              rst_i  = 1'b1;
    logic              trig_i = 1'b0;
    logic              led_o;
    logic              busy_o;
    logic [PEND_W-1:0] pend_o;

    led_blink_drv #(
        .CLK_FREQ (CLK_FREQ),
        .ON_MS    (ON_MS),
        .OFF_MS   (OFF_MS),
        .BLINKS   (BLINKS),
        .PEND_W   (PEND_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .trig_i (trig_i),
        .led_o  (led_o),
        .busy_o (busy_o),
        .pend_o (pend_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] val;
        int         test;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   cur_test = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic string sig_name(int sig);
        case (sig)
            SIG_LED:  return "led";
            SIG_BUSY: return "busy";
            default:  return "pend";
        endcase
    endfunction

    function automatic logic [3:0] observe(int sig);
        case (sig)
            SIG_LED:  return {3'b000, led_o};
            SIG_BUSY: return {3'b000, busy_o};
            default:  return 4'(pend_o);
        endcase
    endfunction

    task automatic check(int sig, logic [3:0] expv, int test);
        logic [3:0] obs;
        obs = observe(sig);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL t%0d_%s cyc %0d: observed %0h expected %0h",
                   test, sig_name(sig), cyc, obs, expv);
        end
    endtask

    // Keep the scoreboard ordered by cycle so step() only ever looks at the head.
    task automatic push_exp(int c, int sig, logic [3:0] v);
        exp_t e;
        int   idx;
        e.cyc  = c;
        e.sig  = sig;
        e.val  = (sig == SIG_LED) ? (v ^ LED_INV) : v;
        e.test = cur_test;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic exp_range(int sig, int c0, int c1, logic [3:0] v);
        for (int c = c0; c <= c1; c++)
            push_exp(c, sig, v);
    endtask

    task automatic exp_idle(int c0, int c1);
        exp_range(SIG_LED,  c0, c1, 4'd0);
        exp_range(SIG_BUSY, c0, c1, 4'd0);
        exp_range(SIG_PEND, c0, c1, 4'd0);
    endtask

    // LED and busy timeline of one full burst whose first lit cycle is s.
    task automatic exp_burst(int s);
        for (int b = 0; b < BLINKS; b++) begin
            exp_range(SIG_LED, s + b * PERIOD, s + b * PERIOD + ON_C - 1, 4'd1);
            exp_range(SIG_LED, s + b * PERIOD + ON_C, s + (b + 1) * PERIOD - 1, 4'd0);
        end
        exp_range(SIG_BUSY, s, s + BURST - 1, 4'd1);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk_i);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check(e.sig, e.val, e.test);
        end
    endtask

    task automatic run_to(int n);
        while (cyc < n)
            step();
    endtask

    task automatic pulse_trig();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
    endtask

    task automatic do_reset(int test);
        cur_test = test;
        rst_i    = 1'b1;
        trig_i   = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1;
        cyc = 0;
        check(SIG_LED,  LED_INV, test);
        check(SIG_BUSY, 4'd0,    test);
        check(SIG_PEND, 4'd0,    test);
        rst_i = 1'b0;
    endtask

    initial begin
        // 1: single event, one burst, no queueing
        do_reset(1);
        exp_idle(1, 10);
        run_to(10);
        exp_burst(11);
        exp_range(SIG_PEND, 11, 20, 4'd0);
        exp_idle(21, 24);
        pulse_trig();
        run_to(24);

        // 2: second event during burst plays back-to-back
        do_reset(2);
        exp_idle(1, 10);
        exp_burst(11);
        exp_burst(21);
        exp_range(SIG_PEND, 11, 12, 4'd0);
        exp_range(SIG_PEND, 13, 20, 4'd1);
        exp_range(SIG_PEND, 21, 30, 4'd0);
        exp_idle(31, 33);
        run_to(10);
        pulse_trig();
        run_to(12);
        pulse_trig();
        run_to(33);

        // 3: five queued events saturate the pending count at 3
        do_reset(3);
        exp_idle(1, 10);
        exp_burst(11);
        exp_burst(21);
        exp_burst(31);
        exp_burst(41);
        exp_range(SIG_PEND, 11, 12, 4'd0);
        exp_range(SIG_PEND, 13, 13, 4'd1);
        exp_range(SIG_PEND, 14, 14, 4'd2);
        exp_range(SIG_PEND, 15, 20, 4'd3);
        exp_range(SIG_PEND, 21, 30, 4'd2);
        exp_range(SIG_PEND, 31, 40, 4'd1);
        exp_range(SIG_PEND, 41, 50, 4'd0);
        exp_idle(51, 55);
        run_to(10);
        pulse_trig();
        run_to(12);
        repeat (5) pulse_trig();
        run_to(55);

        // 4: event on the last OFF cycle restarts without touching pend
        do_reset(4);
        exp_idle(1, 10);
        exp_burst(11);
        exp_burst(21);
        exp_range(SIG_PEND, 11, 30, 4'd0);
        exp_idle(31, 33);
        run_to(10);
        pulse_trig();
        run_to(20);
        pulse_trig();
        run_to(33);

        // 5: reset mid-burst clears everything; trig under reset is ignored
        do_reset(5);
        exp_idle(1, 10);
        exp_range(SIG_LED,  11, 13, 4'd1);
        exp_range(SIG_LED,  14, 15, 4'd0);
        exp_range(SIG_BUSY, 11, 15, 4'd1);
        exp_range(SIG_PEND, 11, 11, 4'd0);
        exp_range(SIG_PEND, 12, 12, 4'd1);
        exp_range(SIG_PEND, 13, 15, 4'd2);
        run_to(10);
        repeat (3) pulse_trig();
        run_to(15);
        exp_idle(16, 26);
        rst_i  = 1'b1;
        trig_i = 1'b1;
        step();
        rst_i  = 1'b0;
        trig_i = 1'b0;
        run_to(26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
